// File: rtl/universal_register_if.sv
// ---------------------------------------------------------------------------
// universal_register_if
//
// Purpose:
//   Bundles the operation controls, parallel data and status flags of a
//   universal_register so the register and its controller connect through
//   one port.
//
// Parameters:
//   WIDTH     data width in bits
//
// Signals:
//   clear     synchronous clear to the register's reset value
//   load      load data_in
//   inc       increment by one
//   dec       decrement by one
//   shl       shift left one bit, ser_in enters the LSB
//   shr       shift right one bit, fill chosen by arith
//   arith     shr only: 1 = replicate MSB, 0 = shift in ser_in
//   ser_in    serial fill bit
//   data_in   parallel load data
//   data_out  register contents
//   carry     registered carry / borrow / shift-out bit
//   ovf       registered overflow / saturation-hit flag
//   zero      data_out == 0, combinational
//
// Modports:
//   master    the controller side that issues operations
//   slave     the register side
// ---------------------------------------------------------------------------
interface universal_register_if #(
    parameter int unsigned WIDTH = 8
);

    logic             clear;
    logic             load;
    logic             inc;
    logic             dec;
    logic             shl;
    logic             shr;
    logic             arith;
    logic             ser_in;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output clear,
        output load,
        output inc,
        output dec,
        output shl,
        output shr,
        output arith,
        output ser_in,
        output data_in,
        input  data_out,
        input  carry,
        input  ovf,
        input  zero
    );

    modport slave (
        input  clear,
        input  load,
        input  inc,
        input  dec,
        input  shl,
        input  shr,
        input  arith,
        input  ser_in,
        input  data_in,
        output data_out,
        output carry,
        output ovf,
        output zero
    );

endinterface

// File: rtl/universal_register.sv
// ---------------------------------------------------------------------------
// universal_register
//
// Purpose:
//   General-purpose datapath register used for the PC, MAR, AC and MQ.
//   It performs one operation per clock, chosen by strict priority:
//   clear > load > inc/dec > shl > shr > hold.
//   Increment and decrement either wrap or clamp, depending on SATURATE.
//   Shifts are logical or arithmetic and never saturate. Every operation
//   also sets a registered carry/shift-out flag and an overflow flag that
//   the AC/MQ sequencing uses for shift and arithmetic steps.
//
// Parameters:
//   WIDTH        data width in bits (>= 2)
//   RESET_VALUE  value taken on rst and on clear
//   SATURATE     0 = inc/dec wrap modulo 2^WIDTH, 1 = clamp at all-ones/zero
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          universal_register_if slave modport (controls, data, flags)
// ---------------------------------------------------------------------------
module universal_register #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    universal_register_if.slave bus
);

    // Boundary patterns that decide carry, overflow and saturation.
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] data_q;
    logic             carry_q;
    logic             ovf_q;

    logic [WIDTH-1:0] data_next;
    logic             carry_next;
    logic             ovf_next;

    logic             is_all_ones;
    logic             is_zero;
    logic             is_max_pos;
    logic             is_min_neg;
    logic             shr_fill;

    // Comparisons against the current contents, shared by several operations.
    assign is_all_ones = (data_q == ALL_ONES);
    assign is_zero     = (data_q == ALL_ZERO);
    assign is_max_pos  = (data_q == MAX_POS);
    assign is_min_neg  = (data_q == MIN_NEG);

    // Arithmetic right shifts keep the sign. Logical right shifts take the
    // serial bit so that AC and MQ can be chained as one double register.
    assign shr_fill = bus.arith ? data_q[WIDTH-1] : bus.ser_in;

    // Next-state selection. Every operation defines all three state
    // elements. The defaults give hold, which also covers inc and dec
    // asserted together: that pair blocks the shifts below it and keeps
    // the flags.
    always_comb begin
        data_next  = data_q;
        carry_next = carry_q;
        ovf_next   = ovf_q;

        if (bus.clear) begin
            data_next  = RESET_VALUE;
            carry_next = 1'b0;
            ovf_next   = 1'b0;
        end else if (bus.load) begin
            data_next  = bus.data_in;
            carry_next = 1'b0;
            ovf_next   = 1'b0;
        end else if (bus.inc && bus.dec) begin
            data_next  = data_q;
            carry_next = carry_q;
            ovf_next   = ovf_q;
        end else if (bus.inc) begin
            if (SATURATE) begin
                // In saturate mode, ovf means the operation hit the clamp.
                // Carry never fires in this mode.
                data_next  = is_all_ones ? data_q : (data_q + ONE);
                carry_next = 1'b0;
                ovf_next   = is_all_ones;
            end else begin
                data_next  = data_q + ONE;
                carry_next = is_all_ones;
                ovf_next   = is_max_pos;
            end
        end else if (bus.dec) begin
            if (SATURATE) begin
                data_next  = is_zero ? data_q : (data_q - ONE);
                carry_next = 1'b0;
                ovf_next   = is_zero;
            end else begin
                // Carry is the borrow out of the subtraction.
                data_next  = data_q - ONE;
                carry_next = is_zero;
                ovf_next   = is_min_neg;
            end
        end else if (bus.shl) begin
            // A left shift overflows when the sign bit changes.
            data_next  = {data_q[WIDTH-2:0], bus.ser_in};
            carry_next = data_q[WIDTH-1];
            ovf_next   = data_q[WIDTH-1] ^ data_q[WIDTH-2];
        end else if (bus.shr) begin
            data_next  = {shr_fill, data_q[WIDTH-1:1]};
            carry_next = data_q[0];
            ovf_next   = 1'b0;
        end
    end

    // The register and both flags update together. Reset is asynchronous,
    // so the reset value shows up on data_out as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= RESET_VALUE;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_next;
            carry_q <= carry_next;
            ovf_q   <= ovf_next;
        end
    end

    // Zero is decoded directly from the register, so it has no extra latency.
    assign bus.data_out = data_q;
    assign bus.carry    = carry_q;
    assign bus.ovf      = ovf_q;
    assign bus.zero     = (data_q == ALL_ZERO);

endmodule

// File: tb/tb_universal_register.sv
// ---------------------------------------------------------------------------
// tb_universal_register
//
// Drives three universal_register instances:
//   sel 0: WIDTH=8,  RESET_VALUE=0x10, wrap mode
//   sel 1: WIDTH=8,  RESET_VALUE=0x00, saturate mode
//   sel 2: WIDTH=16, RESET_VALUE=0x0000, wrap mode
// Each expected result is pushed to a scoreboard queue when its stimulus is
// driven. The result is popped and compared one clock later.
// ---------------------------------------------------------------------------
module tb_universal_register;

    logic clk;
    logic rst;

    int compareCount;
    int failCount;

    // Control word layout: {clear, load, inc, dec, shl, shr, arith, ser_in}
    localparam logic [7:0] CLR  = 8'h80;
    localparam logic [7:0] LD   = 8'h40;
    localparam logic [7:0] INC  = 8'h20;
    localparam logic [7:0] DEC  = 8'h10;
    localparam logic [7:0] SHL  = 8'h08;
    localparam logic [7:0] SHR  = 8'h04;
    localparam logic [7:0] ARI  = 8'h02;
    localparam logic [7:0] SER  = 8'h01;
    localparam logic [7:0] IDLE = 8'h00;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] data;
        logic        carry;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t sb[$];

    universal_register_if #(.WIDTH(8))  bw ();
    universal_register_if #(.WIDTH(8))  bs ();
    universal_register_if #(.WIDTH(16)) bl ();

    universal_register #(.WIDTH(8), .RESET_VALUE(8'h10), .SATURATE(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    universal_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bs.slave)
    );

    universal_register #(.WIDTH(16), .RESET_VALUE(16'h0000), .SATURATE(1'b0)) dut_w16 (
        .clk (clk),
        .rst (rst),
        .bus (bl.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Clears the controls of all three instances, then drives the selected one.
    task automatic driveInputs(input int sel, input logic [7:0] ctrl, input logic [15:0] din);
        {bw.clear, bw.load, bw.inc, bw.dec, bw.shl, bw.shr, bw.arith, bw.ser_in} = 8'h00;
        {bs.clear, bs.load, bs.inc, bs.dec, bs.shl, bs.shr, bs.arith, bs.ser_in} = 8'h00;
        {bl.clear, bl.load, bl.inc, bl.dec, bl.shl, bl.shr, bl.arith, bl.ser_in} = 8'h00;
        bw.data_in = 8'h00;
        bs.data_in = 8'h00;
        bl.data_in = 16'h0000;
        case (sel)
            0: begin
                {bw.clear, bw.load, bw.inc, bw.dec, bw.shl, bw.shr, bw.arith, bw.ser_in} = ctrl;
                bw.data_in = din[7:0];
            end
            1: begin
                {bs.clear, bs.load, bs.inc, bs.dec, bs.shl, bs.shr, bs.arith, bs.ser_in} = ctrl;
                bs.data_in = din[7:0];
            end
            default: begin
                {bl.clear, bl.load, bl.inc, bl.dec, bl.shl, bl.shr, bl.arith, bl.ser_in} = ctrl;
                bl.data_in = din;
            end
        endcase
    endtask

    // Pops the oldest expectation and compares it with the selected instance.
    task automatic collectOutput();
        exp_t        e;
        logic [15:0] obsData;
        logic        obsCarry;
        logic        obsOvf;
        logic        obsZero;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        case (e.sel)
            0:       begin obsData = 16'(bw.data_out); obsCarry = bw.carry; obsOvf = bw.ovf; obsZero = bw.zero; end
            1:       begin obsData = 16'(bs.data_out); obsCarry = bs.carry; obsOvf = bs.ovf; obsZero = bs.zero; end
            default: begin obsData = bl.data_out;      obsCarry = bl.carry; obsOvf = bl.ovf; obsZero = bl.zero; end
        endcase
        checkOutput({e.tag, ".data"},  obsData,          e.data);
        checkOutput({e.tag, ".carry"}, 16'(obsCarry),    16'(e.carry));
        checkOutput({e.tag, ".ovf"},   16'(obsOvf),      16'(e.ovf));
        checkOutput({e.tag, ".zero"},  16'(obsZero),     16'(e.zero));
    endtask

    // Called 1 time unit after a rising edge. Drives one operation, records
    // the expected result, waits one clock and checks it.
    task automatic applyStimulus(input string tag, input int sel, input logic [7:0] ctrl,
                                 input logic [15:0] din, input logic [15:0] expData,
                                 input logic expCarry, input logic expOvf);
        exp_t e;
        driveInputs(sel, ctrl, din);
        e.tag   = tag;
        e.sel   = sel;
        e.data  = expData;
        e.carry = expCarry;
        e.ovf   = expOvf;
        e.zero  = (expData == 16'h0000);
        sb.push_back(e);
        @(posedge clk);
        #1;
        collectOutput();
    endtask

    // Pulses rst between two edges while a load is pending. The reset value
    // must appear at once, and the next edge must still perform the load.
    task automatic resetPulseTest();
        exp_t e;
        driveInputs(0, LD, 16'h005A);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async.data",  16'(bw.data_out), 16'h0010);
        checkOutput("rst_async.carry", 16'(bw.carry),    16'h0000);
        checkOutput("rst_async.ovf",   16'(bw.ovf),      16'h0000);
        checkOutput("rst_async.zero",  16'(bw.zero),     16'h0000);
        #1;
        rst = 1'b0;
        e.tag   = "rst_then_load";
        e.sel   = 0;
        e.data  = 16'h005A;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        e.zero  = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        collectOutput();
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        rst          = 1'b1;
        driveInputs(0, IDLE, 16'h0000);
        repeat (2) @(posedge clk);
        #1;

        checkOutput("reset_wrap.data",  16'(bw.data_out), 16'h0010);
        checkOutput("reset_wrap.carry", 16'(bw.carry),    16'h0000);
        checkOutput("reset_wrap.ovf",   16'(bw.ovf),      16'h0000);
        checkOutput("reset_wrap.zero",  16'(bw.zero),     16'h0000);
        checkOutput("reset_sat.data",   16'(bs.data_out), 16'h0000);
        checkOutput("reset_sat.zero",   16'(bs.zero),     16'h0001);
        checkOutput("reset_w16.data",   bl.data_out,      16'h0000);
        checkOutput("reset_w16.zero",   16'(bl.zero),     16'h0001);
        rst = 1'b0;

        // Set both flags, then check that an asynchronous reset clears them.
        applyStimulus("w_ld80",      0, LD,  16'h0080, 16'h0080, 1'b0, 1'b0);
        applyStimulus("w_shl80",     0, SHL, 16'h0000, 16'h0000, 1'b1, 1'b1);
        resetPulseTest();

        // Wrap-mode increment and decrement at their boundaries.
        applyStimulus("w_ldFF",      0, LD,  16'h00FF, 16'h00FF, 1'b0, 1'b0);
        applyStimulus("w_incFF",     0, INC, 16'h0000, 16'h0000, 1'b1, 1'b0);
        applyStimulus("w_dec00",     0, DEC, 16'h0000, 16'h00FF, 1'b1, 1'b0);
        applyStimulus("w_ld7F",      0, LD,  16'h007F, 16'h007F, 1'b0, 1'b0);
        applyStimulus("w_inc7F",     0, INC, 16'h0000, 16'h0080, 1'b0, 1'b1);
        applyStimulus("w_hold_ovf",  0, IDLE,16'h0000, 16'h0080, 1'b0, 1'b1);
        applyStimulus("w_dec80",     0, DEC, 16'h0000, 16'h007F, 1'b0, 1'b1);
        applyStimulus("w_dec7F",     0, DEC, 16'h0000, 16'h007E, 1'b0, 1'b0);

        // Shifts.
        applyStimulus("w_ld96",      0, LD,        16'h0096, 16'h0096, 1'b0, 1'b0);
        applyStimulus("w_shr_arith", 0, SHR | ARI, 16'h0000, 16'h00CB, 1'b0, 1'b0);
        applyStimulus("w_shr_log",   0, SHR,       16'h0000, 16'h0065, 1'b1, 1'b0);
        applyStimulus("w_shl_ser1",  0, SHL | SER, 16'h0000, 16'h00CB, 1'b0, 1'b1);
        applyStimulus("w_shr_ser1",  0, SHR | SER, 16'h0000, 16'h00E5, 1'b1, 1'b0);

        // Simultaneous controls.
        applyStimulus("w_clr_ld_inc",0, CLR | LD | INC, 16'h0033, 16'h0010, 1'b0, 1'b0);
        applyStimulus("w_ld_inc",    0, LD | INC,       16'h0033, 16'h0033, 1'b0, 1'b0);
        applyStimulus("w_incdec_shl",0, INC | DEC | SHL,16'h0000, 16'h0033, 1'b0, 1'b0);
        applyStimulus("w_shl_shr",   0, SHL | SHR,      16'h0000, 16'h0066, 1'b0, 1'b0);
        applyStimulus("w_ldC0",      0, LD,             16'h00C0, 16'h00C0, 1'b0, 1'b0);
        applyStimulus("w_shlC0",     0, SHL,            16'h0000, 16'h0080, 1'b1, 1'b0);
        applyStimulus("w_incdec_hold",0,INC | DEC | SHR,16'h0000, 16'h0080, 1'b1, 1'b0);
        applyStimulus("w_clear",     0, CLR,            16'h0000, 16'h0010, 1'b0, 1'b0);

        // Saturate mode.
        applyStimulus("s_ldFE",      1, LD,  16'h00FE, 16'h00FE, 1'b0, 1'b0);
        applyStimulus("s_inc1",      1, INC, 16'h0000, 16'h00FF, 1'b0, 1'b0);
        applyStimulus("s_inc2",      1, INC, 16'h0000, 16'h00FF, 1'b0, 1'b1);
        applyStimulus("s_inc3",      1, INC, 16'h0000, 16'h00FF, 1'b0, 1'b1);
        applyStimulus("s_ld01",      1, LD,  16'h0001, 16'h0001, 1'b0, 1'b0);
        applyStimulus("s_dec1",      1, DEC, 16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus("s_dec2",      1, DEC, 16'h0000, 16'h0000, 1'b0, 1'b1);
        applyStimulus("s_ld80",      1, LD,  16'h0080, 16'h0080, 1'b0, 1'b0);
        applyStimulus("s_shl80",     1, SHL, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // 16-bit wrap, then idle cycles that must hold the data and flags.
        applyStimulus("l_ldFFFF",    2, LD,   16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus("l_incFFFF",   2, INC,  16'h0000, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("l_idle%0d", i), 2, IDLE, 16'h0000, 16'h0000, 1'b1, 1'b0);
        end
        applyStimulus("l_ld8001",    2, LD,        16'h8001, 16'h8001, 1'b0, 1'b0);
        applyStimulus("l_shr_arith", 2, SHR | ARI, 16'h0000, 16'hC000, 1'b1, 1'b0);
        applyStimulus("l_ld7FFF",    2, LD,        16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        applyStimulus("l_inc7FFF",   2, INC,       16'h0000, 16'h8000, 1'b0, 1'b1);

        checkOutput("sb_empty", 16'(sb.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
Parametrised general-purpose datapath register. It replaces fixed 8-bit load/clear/inc registers for the PC, MAR, AC and MQ. It adds decrement, logical/arithmetic shifts, and wrap or saturate modes. It also provides a registered carry/shift-out flag, an overflow flag and a zero flag, which AC and MQ use for IAS shift and arithmetic sequencing.

Parameters:
WIDTH, 8, data width in bits (>= 2)
RESET_VALUE, 0, value loaded into data_out on rst and on clear
SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec clamp at all-ones / zero

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear to RESET_VALUE
load  input  1  load data_in
inc  input  1  increment by 1
dec  input  1  decrement by 1
shl  input  1  shift left one bit; ser_in enters LSB
shr  input  1  shift right one bit; MSB fill selected by arith
arith  input  1  shr only: 1 = replicate MSB, 0 = shift in ser_in
ser_in  input  1  serial fill bit for shl and logical shr
data_in  input  WIDTH  parallel load data
data_out  output  WIDTH  register contents
carry  output  1  registered carry/borrow/shift-out bit
ovf  output  1  registered overflow/saturation-hit flag
zero  output  1  combinational: data_out == 0

Behaviour:
- Reset: rst high asynchronously forces data_out = RESET_VALUE, carry = 0, ovf = 0, regardless of clk or any other input. Deassertion is registered normally; the first edge after deassertion acts on the inputs present at that edge.
- All other updates occur on the rising edge of clk; data_out, carry and ovf change together with one-cycle latency.
- Strict priority, one operation per cycle: clear > load > (inc/dec) > shl > shr > hold.
- clear: data_out = RESET_VALUE, carry = 0, ovf = 0.
- load: data_out = data_in, carry = 0, ovf = 0.
- inc and dec both high (no clear/load): treat as hold. data_out, carry and ovf are unchanged, and shl/shr are ignored that cycle.
- inc alone:
  - Wrap mode: data_out = data_out + 1 truncated to WIDTH. carry = 1 iff the old value was all-ones, otherwise 0. ovf = 1 iff the old value was 0111..1 (signed overflow), otherwise 0.
  - Saturate mode, old value all-ones: data_out stays all-ones, carry = 0, ovf = 1.
  - Saturate mode, otherwise: +1, carry = 0, ovf = 0.
- dec alone:
  - Wrap mode: data_out = data_out - 1 modulo 2^WIDTH. carry (borrow) = 1 iff the old value was 0. ovf = 1 iff the old value was 1000..0.
  - Saturate mode, old value 0: data_out stays 0, carry = 0, ovf = 1.
  - Saturate mode, otherwise: -1, carry = 0, ovf = 0.
- shl: data_out = {data_out[WIDTH-2:0], ser_in}. carry = old data_out[WIDTH-1]. ovf = 1 iff the old bits [WIDTH-1] and [WIDTH-2] differ (sign change).
- shr: data_out = {fill, data_out[WIDTH-1:1]}, where fill = old MSB if arith else ser_in. carry = old data_out[0]. ovf = 0.
- shl and shr both high: shl wins (priority rule).
- Hold (no operation): all registers keep their value; flags are not cleared.
- zero: purely combinational from data_out, with no extra latency.
- SATURATE is irrelevant to shifts. Shifts never saturate.

Test Plan:
- rst pulse mid-cycle while load=1, data_in=0x5A, with RESET_VALUE=0x10 -> data_out = 0x10, carry = 0, ovf = 0 immediately (before the next edge); next edge with rst low loads 0x5A.
- WIDTH=8, SATURATE=0: load 0xFF, then inc -> data_out = 0x00, carry = 1, zero = 1. Then dec -> 0xFF, carry = 1. Load 0x7F, inc -> 0x80, ovf = 1.
- SATURATE=1: load 0xFE, inc, inc, inc -> 0xFF, 0xFF, 0xFF, with ovf = 0, 1, 1. Then load 0x01, dec, dec -> 0x00, then 0x00 with ovf = 1.
- Load 0x96: shr with arith=1 -> 0xCB, carry = 0. shr with arith=0, ser_in=0 -> 0x65, carry = 1. shl with ser_in=1 -> 0xCB, carry = 0, ovf = 1.
- Simultaneous controls:
  - clear+load+inc with data_in=0x33 -> RESET_VALUE.
  - load+inc -> 0x33.
  - inc+dec+shl from 0x33 -> 0x33 with flags unchanged.
  - shl+shr from 0x33 with ser_in=0 -> 0x66.
- WIDTH=16: load 0xFFFF, inc -> 0x0000, carry = 1. Idle 3 cycles -> data_out = 0x0000 and carry = 1 held.
